// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter (reverse double-dabble): one right shift of {D,B}
// per clock followed by a subtract-3 fix on every BCD digit, with start/busy/done handshake.
module bcd_to_bin_converter #(
   parameter int BIN_WIDTH = 6,
   parameter int DEC_WIDTH = 2
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [DEC_WIDTH*4-1:0] bcd_in,
   output logic                   busy,
   output logic                   done,
   output logic [BIN_WIDTH-1:0]   bin_out,
   output logic                   ovf,
   output logic                   err
);

   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam int DW = DEC_WIDTH * 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [DW-1:0]        r_d, w_d_nxt, w_d_shift, w_d_corr;
   logic [BIN_WIDTH-1:0] r_b, w_b_nxt, w_b_shift;
   logic [BIN_WIDTH:0]   w_db_cat;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic                 r_e, w_e_nxt;
   logic                 w_last;
   logic                 r_busy, w_busy_nxt;
   logic                 r_done, w_done_nxt;
   logic [BIN_WIDTH-1:0] r_bin, w_bin_nxt;
   logic                 r_ovf, w_ovf_nxt;
   logic                 r_err, w_err_nxt;

   // A digit that received the shifted-in LSB of its upper neighbour reads 8+; subtract 3 to fold 8 back to 5.
   function automatic logic [3:0] digit_fix(input logic [3:0] dig);
      if (dig >= 4'd8) begin
         return dig - 4'd3;
      end else begin
         return dig;
      end
   endfunction

   function automatic logic any_bad_digit(input logic [DW-1:0] bcd);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DEC_WIDTH; i++) begin
         bad = bad | (bcd[i*4 +: 4] > 4'd9);
      end
      return bad;
   endfunction

   assign w_db_cat  = {r_d[0], r_b};
   assign w_b_shift = w_db_cat[BIN_WIDTH:1];
   assign w_d_shift = r_d >> 1;
   assign w_last    = (r_cnt == CW'(BIN_WIDTH - 1));

   for (genvar g = 0; g < DEC_WIDTH; g++) begin : g_digit_fix
      assign w_d_corr[g*4 +: 4] = digit_fix(w_d_shift[g*4 +: 4]);
   end

   // Next-state and next-datapath logic; every register holds unless the state says otherwise.
   always_comb begin
      w_state_nxt = r_state;
      w_d_nxt     = r_d;
      w_b_nxt     = r_b;
      w_cnt_nxt   = r_cnt;
      w_e_nxt     = r_e;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_bin_nxt   = r_bin;
      w_ovf_nxt   = r_ovf;
      w_err_nxt   = r_err;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_d_nxt     = bcd_in;
               w_b_nxt     = {BIN_WIDTH{1'b0}};
               w_cnt_nxt   = {CW{1'b0}};
               w_e_nxt     = any_bad_digit(bcd_in);
               w_busy_nxt  = 1'b1;
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            w_d_nxt   = w_d_corr;
            w_b_nxt   = w_b_shift;
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_last) begin
               w_bin_nxt   = r_e ? {BIN_WIDTH{1'b0}} : w_b_shift;
               w_ovf_nxt   = r_e ? 1'b0 : (w_d_corr != {DW{1'b0}});
               w_err_nxt   = r_e;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_d    <= {DW{1'b0}};
         r_b    <= {BIN_WIDTH{1'b0}};
         r_cnt  <= {CW{1'b0}};
         r_e    <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_bin  <= {BIN_WIDTH{1'b0}};
         r_ovf  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_d    <= w_d_nxt;
         r_b    <= w_b_nxt;
         r_cnt  <= w_cnt_nxt;
         r_e    <= w_e_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_bin  <= w_bin_nxt;
         r_ovf  <= w_ovf_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign bin_out = r_bin;
   assign ovf     = r_ovf;
   assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Self-checking bench for bcd_to_bin_converter: directed cases plus random BCD words
// compared against an arithmetic decimal-value reference model.
module tb_bcd_to_bin_converter;

   localparam int BW = 6;
   localparam int DW = 2;

   logic          sys_clk;
   logic          rst_n;
   logic          start;
   logic [DW*4-1:0] bcd_in;
   logic          busy;
   logic          done;
   logic [BW-1:0] bin_out;
   logic          ovf;
   logic          err;

   int n_vec = 0;
   int n_err = 0;

   bcd_to_bin_converter #(.BIN_WIDTH(BW), .DEC_WIDTH(DW)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .ovf     (ovf),
      .err     (err)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Decimal value of the BCD word and whether any digit is out of range.
   function automatic void ref_model(input logic [DW*4-1:0] bcd, output int value, output bit bad);
      int scale;
      value = 0;
      bad   = 1'b0;
      scale = 1;
      for (int i = 0; i < DW; i++) begin
         int dig;
         dig = int'((bcd >> (4 * i)) & 'hF);
         if (dig > 9) bad = 1'b1;
         value = value + dig * scale;
         scale = scale * 10;
      end
   endfunction

   task automatic run_conv(input logic [DW*4-1:0] bcd, input bit disturb);
      int cyc;
      int nb;
      int v;
      int extra;
      bit e;
      int exp_bin;
      int exp_ovf;
      ref_model(bcd, v, e);
      exp_bin = e ? 0 : (v % (1 << BW));
      exp_ovf = e ? 0 : ((v >= (1 << BW)) ? 1 : 0);
      start  = 1'b1;
      bcd_in = bcd;
      tick();
      start = 1'b0;
      cyc = 0;
      nb  = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && cyc < 20) begin
         if (disturb && cyc == 2) begin
            start  = 1'b1;
            bcd_in = 8'h77;
         end else if (disturb && cyc == 3) begin
            start  = 1'b0;
            bcd_in = 8'h99;
         end
         tick();
         cyc++;
         if (busy === 1'b1) nb++;
      end
      start = 1'b0;
      check("latency", cyc, BW);
      check("busy_cycles", nb, BW);
      check("busy_at_done", busy, 0);
      check("bin_out", bin_out, exp_bin);
      check("ovf", ovf, exp_ovf);
      check("err", err, e ? 1 : 0);
      tick();
      check("done_pulse", done, 0);
      check("bin_hold", bin_out, exp_bin);
      if (disturb) begin
         extra = 0;
         repeat (8) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) extra++;
         end
         check("no_second_conv", extra, 0);
      end
   endtask

   initial begin
      int cyc;
      int gap;
      int held_bad;
      int extra;
      logic [DW*4-1:0] rnd;

      rst_n  = 1'b0;
      start  = 1'b0;
      bcd_in = 8'h00;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bin", bin_out, 0);
      check("rst_ovf", ovf, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      run_conv(8'h42, 1'b0);
      run_conv(8'h63, 1'b0);
      run_conv(8'h64, 1'b0);
      run_conv(8'h99, 1'b0);
      run_conv(8'h5A, 1'b0);
      run_conv(8'hA3, 1'b0);
      run_conv(8'h12, 1'b1);

      // Held start: two back-to-back conversions, 0 then 1.
      start  = 1'b1;
      bcd_in = 8'h00;
      tick();
      bcd_in = 8'h01;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("held_latency", cyc, BW);
      check("held_bin0", bin_out, 0);
      gap = 0;
      held_bad = 0;
      do begin
         tick();
         gap++;
         if (done !== 1'b1 && bin_out !== 6'd0) held_bad++;
      end while (done !== 1'b1 && gap < 20);
      start = 1'b0;
      check("held_gap", gap, BW + 1);
      check("held_hold", held_bad, 0);
      check("held_bin1", bin_out, 1);
      tick();
      check("held_stop_busy", busy, 0);

      // Reset in the 4th busy cycle abandons the conversion.
      start  = 1'b1;
      bcd_in = 8'h55;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_bin", bin_out, 0);
      rst_n = 1'b1;
      extra = 0;
      repeat (10) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) extra++;
      end
      check("midrst_no_done", extra, 0);
      run_conv(8'h07, 1'b0);

      // Random BCD words, mostly valid digits with occasional out-of-range ones.
      for (int k = 0; k < 30; k++) begin
         for (int d = 0; d < DW; d++) begin
            if ($urandom_range(0, 3) == 0) rnd[d*4 +: 4] = 4'($urandom_range(0, 15));
            else                           rnd[d*4 +: 4] = 4'($urandom_range(0, 9));
         end
         run_conv(rnd, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin_converter.md
Name: bcd_to_bin_converter

Overview:
Sequential BCD-to-binary converter, the inverse of the team's binary-to-BCD path. It uses the reverse double-dabble algorithm: one right shift per clock, then a subtract-3 correction on each digit. It converts a packed DEC_WIDTH-digit BCD word to a BIN_WIDTH-bit unsigned binary value, with a start/busy/done handshake. It flags invalid BCD digits and results that do not fit in BIN_WIDTH bits.

Parameters:
BIN_WIDTH, 6, width of the binary result and number of shift iterations (>=1).
DEC_WIDTH, 2, number of BCD digits in the input (>=1); input width is DEC_WIDTH*4.

Ports:
sys_clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request a conversion; sampled only when idle.
bcd_in  input  DEC_WIDTH*4  packed BCD input; digit 0 is in [3:0]. Captured on the accepted start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bin_out, ovf and err are updated.
bin_out  output  BIN_WIDTH  binary result; holds its value until the next done.
ovf  output  1  BCD value is >= 2^BIN_WIDTH; bin_out then holds the value mod 2^BIN_WIDTH. Valid with done, held after.
err  output  1  at least one input digit was >9; valid with done, held after.

Behaviour:
- Reset: rst_n low at an edge forces state IDLE and clears busy, done, bin_out, ovf, err, all internal registers and the counter. This applies mid-conversion too: the conversion is abandoned and no done is issued.
- Internal registers:
  - D: DEC_WIDTH*4 bits, the remaining BCD.
  - B: BIN_WIDTH bits, the binary accumulator.
  - cnt: width clog2(BIN_WIDTH+1).
  - e: latched error flag.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - D<=bcd_in, B<=0, cnt<=0.
  - e<=OR over all digits of (digit>9).
  - busy<=1, state<=SHIFT.
- IDLE, start=0: all registers hold. done is 0 except in the cycle after the completion edge.
- SHIFT, each edge:
  - Shift {D,B} right by 1: B<={D[0],B[BIN_WIDTH-1:1]}, D<=D>>1.
  - Correction: on the post-shift D, each 4-bit digit >=8 has 3 subtracted. This is the same-cycle combinational result, registered at that edge.
  - cnt<=cnt+1.
- SHIFT, edge where cnt==BIN_WIDTH-1 (edge E_N, N=BIN_WIDTH):
  - Perform the final shift.
  - bin_out<=next B, or 0 if e.
  - ovf<=(next D != 0), or 0 if e.
  - err<=e.
  - done<=1, busy<=0, state<=IDLE.
- Latency: busy is high in cycles E0+1 through E_N. done is high only in the cycle after E_N, which is N cycles after the accepted start edge. Throughput is one conversion per N+1 cycles.
- done is a single-cycle pulse; it is cleared at the next edge.
- start while busy is ignored, and bcd_in changes during SHIFT have no effect.
- start=1 in the cycle where done=1 is accepted because state is IDLE. done clears and busy rises at the same edge.
- Held start: a new conversion begins each time the block returns to IDLE.
- The invariant after k shifts is: B[BIN_WIDTH-1:BIN_WIDTH-k] holds the low k bits of the value, and D holds floor(value/2^k) in BCD. ovf is therefore exact.
- Only the first two digits were wired in the earlier BCD path; this block is fully parameterised by DEC_WIDTH, with the digit correction generated per digit.

Test Plan:
- Reset, then start with bcd_in=8'h42 -> done exactly 6 cycles after the start edge; bin_out=6'h2A (42), ovf=0, err=0; busy high for 6 cycles.
- bcd_in=8'h63 -> bin_out=63, ovf=0. bcd_in=8'h64 -> bin_out=0, ovf=1. bcd_in=8'h99 -> bin_out=35, ovf=1.
- bcd_in=8'h5A (digit 0 = 10) -> done after 6 cycles; err=1, bin_out=0, ovf=0.
- Start 8'h12; pulse start with 8'h77 at the 3rd busy cycle; change bcd_in mid-run -> single done, bin_out=12, no second conversion.
- Hold start high continuously over 8'h00 then 8'h01 -> done pulses 7 cycles apart; results 0 then 1; outputs hold between pulses.
- Assert rst_n=0 at the 4th busy cycle of 8'h55 -> next cycle busy=0, done=0, bin_out=0; no done follows. A new start with 8'h07 then yields 7.
